seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers four hex digits from a multiplexed active-low 7-segment scan; SEG7_DEC_DP_EN also captures decimal points.
// FRAME_VALID follows the last position's pair by 2 + STABLE_CYC + 1 cycles; no backpressure, inputs are sampled every cycle.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic       CLK,
  input  logic       IN_CLR,
  input  logic [3:0] DIGIT,
  input  logic [7:0] PATTERN,
  output logic [3:0] Q1,
  output logic [3:0] Q2,
  output logic [3:0] Q3,
  output logic [3:0] Q4,
  output logic [3:0] DP,
  output logic       FRAME_VALID,
  output logic       ERR
);

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

  localparam logic [7:0] CNT_PRE  = 8'(STABLE_CYC - 2);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

`ifdef SEG7_DEC_DP_EN
  localparam logic [7:0] PAT_IGNORE = 8'h00;
`else
  // Forcing dp high at the input removes it from capture and the stability compare.
  localparam logic [7:0] PAT_IGNORE = 8'h01;
`endif

  logic [3:0]      dig_s1_q, dig_s2_q, dig_prev_q;
  logic [7:0]      pat_s1_q, pat_s2_q, pat_prev_q;
  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0][3:0] q_q, q_d;
  logic            fv_q, fv_d;
  logic            err_q, err_d;
  logic            blank, pair_same, capture, legal;
  logic [3:0]      pos_oh;
  logic [4:0]      dec;

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: seg_decode = {1'b1, 4'h0};
      7'b0110000: seg_decode = {1'b1, 4'h1};
      7'b1101101: seg_decode = {1'b1, 4'h2};
      7'b1111001: seg_decode = {1'b1, 4'h3};
      7'b0110011: seg_decode = {1'b1, 4'h4};
      7'b1011011: seg_decode = {1'b1, 4'h5};
      7'b1011111: seg_decode = {1'b1, 4'h6};
      7'b1110000: seg_decode = {1'b1, 4'h7};
      7'b1111111: seg_decode = {1'b1, 4'h8};
      7'b1111011: seg_decode = {1'b1, 4'h9};
      7'b1110111: seg_decode = {1'b1, 4'hA};
      7'b0011111: seg_decode = {1'b1, 4'hB};
      7'b1001110: seg_decode = {1'b1, 4'hC};
      7'b0111101: seg_decode = {1'b1, 4'hD};
      7'b1001111: seg_decode = {1'b1, 4'hE};
      7'b1000111: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    blank     = (dig_s2_q == 4'hF);
    pair_same = (dig_s2_q == dig_prev_q) && (pat_s2_q == pat_prev_q);
    dec       = seg_decode(~pat_s2_q[7:1]);
    case (dig_s2_q)
      4'b1110: pos_oh = 4'b0001;
      4'b1101: pos_oh = 4'b0010;
      4'b1011: pos_oh = 4'b0100;
      4'b0111: pos_oh = 4'b1000;
      default: pos_oh = 4'b0000;
    endcase
    legal = (pos_oh != 4'b0000) && dec[4];

    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      WAIT: begin
        if (!blank) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (blank) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (!pair_same) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_PRE) begin
          state_d = HELD;
          cnt_d   = CNT_LAST;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!pair_same) begin
          state_d = blank ? WAIT : SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase

    // Frame publish clears the mask first so a same-edge capture lands in the new frame.
    fv_d     = (mask_q == 4'hF);
    mask_d   = fv_d ? 4'h0 : mask_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    if (capture) begin
      if (legal) begin
        mask_d = mask_d | pos_oh;
        for (int i = 0; i < 4; i++) begin
          if (pos_oh[i]) shadow_d[i] = dec[3:0];
        end
      end else begin
        err_d = 1'b1;
      end
    end
    q_d = fv_d ? shadow_q : q_q;
  end

  always_ff @(posedge CLK or negedge IN_CLR) begin
    if (!IN_CLR) begin
      dig_s1_q   <= 4'hF;
      dig_s2_q   <= 4'hF;
      dig_prev_q <= 4'hF;
      pat_s1_q   <= 8'hFF;
      pat_s2_q   <= 8'hFF;
      pat_prev_q <= 8'hFF;
      state_q    <= WAIT;
      cnt_q      <= '0;
      mask_q     <= '0;
      shadow_q   <= '0;
      q_q        <= '0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dig_s1_q   <= DIGIT;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
      pat_s1_q   <= PATTERN | PAT_IGNORE;
      pat_s2_q   <= pat_s1_q;
      pat_prev_q <= pat_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      q_q        <= q_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
    end
  end

`ifdef SEG7_DEC_DP_EN
  logic [3:0] dp_shadow_q, dp_shadow_d, dp_q, dp_d;

  always_comb begin
    dp_shadow_d = dp_shadow_q;
    if (capture && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (pos_oh[i]) dp_shadow_d[i] = ~pat_s2_q[0];
      end
    end
    dp_d = fv_d ? dp_shadow_q : dp_q;
  end

  always_ff @(posedge CLK or negedge IN_CLR) begin
    if (!IN_CLR) begin
      dp_shadow_q <= '0;
      dp_q        <= '0;
    end else begin
      dp_shadow_q <= dp_shadow_d;
      dp_q        <= dp_d;
    end
  end

  assign DP = dp_q;
`else
  assign DP = 4'b0000;
`endif

  assign Q1          = q_q[0];
  assign Q2          = q_q[1];
  assign Q3          = q_q[2];
  assign Q4          = q_q[3];
  assign FRAME_VALID = fv_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (STABLE_CYC=4): scan frames, stability boundary, illegal inputs, resets.
module tb_seg7_scan_decoder;

  logic       CLK = 1'b0;
  logic       IN_CLR;
  logic [3:0] DIGIT;
  logic [7:0] PATTERN;
  logic [3:0] Q1, Q2, Q3, Q4, DP;
  logic       FRAME_VALID, ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int err_cnt  = 0;
  int qchg_bad = 0;
  logic [19:0] q_last = '0;
  logic        rst_prev_hi = 1'b0;

  seg7_scan_decoder #(.STABLE_CYC(4)) dut (
    .CLK(CLK), .IN_CLR(IN_CLR), .DIGIT(DIGIT), .PATTERN(PATTERN),
    .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .DP(DP),
    .FRAME_VALID(FRAME_VALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Pulse counters, plus detection of output changes outside FRAME_VALID cycles.
  always @(negedge CLK) begin
    if (FRAME_VALID) fv_cnt++;
    if (ERR) err_cnt++;
    if (IN_CLR && rst_prev_hi && ({Q4, Q3, Q2, Q1, DP} !== q_last) && !FRAME_VALID) qchg_bad++;
    q_last      = {Q4, Q3, Q2, Q1, DP};
    rst_prev_hi = IN_CLR;
  end

  task automatic drive(input logic [3:0] d, input logic [7:0] p, input int n);
    DIGIT   = d;
    PATTERN = p;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_reset();
    #2 IN_CLR = 1'b0;
    @(negedge CLK);
    #2 IN_CLR = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int b;
    IN_CLR = 1'b1; DIGIT = 4'hF; PATTERN = 8'hFF;
    #1 IN_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (Q1 !== 4'h0) begin n_fail++; $display("FAIL reset_q1: got %h expected 0", Q1); end
    n_checks++; if (Q2 !== 4'h0) begin n_fail++; $display("FAIL reset_q2: got %h expected 0", Q2); end
    n_checks++; if (Q3 !== 4'h0) begin n_fail++; $display("FAIL reset_q3: got %h expected 0", Q3); end
    n_checks++; if (Q4 !== 4'h0) begin n_fail++; $display("FAIL reset_q4: got %h expected 0", Q4); end
    n_checks++; if (DP !== 4'h0) begin n_fail++; $display("FAIL reset_dp: got %b expected 0000", DP); end
    n_checks++; if ({FRAME_VALID, ERR} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {FRAME_VALID, ERR}); end
    #2 IN_CLR = 1'b1;
    @(negedge CLK);
    b = fv_cnt;
    drive(4'hF, 8'hFF, 20);
    n_checks++; if (fv_cnt - b !== 0) begin n_fail++; $display("FAIL reset_release_fv: got %0d expected 0", fv_cnt - b); end
    n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL reset_release_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_frame();
    int bf, be, lat;
    bf = fv_cnt; be = err_cnt; lat = 0;
    drive(4'b1110, 8'h9F, 8);
    drive(4'b1101, 8'h71, 8);
    drive(4'b1011, 8'h11, 8);
    DIGIT = 4'b0111; PATTERN = 8'h49;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (FRAME_VALID && lat == 0) lat = i;
    end
    drive(4'hF, 8'hFF, 10);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL frame_latency: got %0d expected 7", lat); end
    n_checks++; if (fv_cnt - bf !== 1) begin n_fail++; $display("FAIL frame_fv_count: got %0d expected 1", fv_cnt - bf); end
    n_checks++; if (err_cnt - be !== 0) begin n_fail++; $display("FAIL frame_err_count: got %0d expected 0", err_cnt - be); end
    n_checks++; if (Q1 !== 4'h1) begin n_fail++; $display("FAIL frame_q1: got %h expected 1", Q1); end
    n_checks++; if (Q2 !== 4'hF) begin n_fail++; $display("FAIL frame_q2: got %h expected f", Q2); end
    n_checks++; if (Q3 !== 4'hA) begin n_fail++; $display("FAIL frame_q3: got %h expected a", Q3); end
    n_checks++; if (Q4 !== 4'h5) begin n_fail++; $display("FAIL frame_q4: got %h expected 5", Q4); end
    n_checks++; if (DP !== 4'h0) begin n_fail++; $display("FAIL frame_dp: got %b expected 0000", DP); end
  endtask

  task automatic test_async_reset();
    int b;
    #2 IN_CLR = 1'b0;
    #1;
    n_checks++; if ({Q4, Q3, Q2, Q1} !== 16'h0000) begin n_fail++; $display("FAIL async_reset_q: got %h expected 0000", {Q4, Q3, Q2, Q1}); end
    n_checks++; if ({FRAME_VALID, ERR, DP} !== 6'b0) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 000000", {FRAME_VALID, ERR, DP}); end
    @(negedge CLK);
    #2 IN_CLR = 1'b1;
    @(negedge CLK);
    b = fv_cnt;
    drive(4'hF, 8'hFF, 20);
    n_checks++; if (fv_cnt - b !== 0) begin n_fail++; $display("FAIL async_release_fv: got %0d expected 0", fv_cnt - b); end
  endtask

  task automatic test_unstable();
    int bf, be;
    bf = fv_cnt; be = err_cnt;
    for (int r = 0; r < 6; r++) begin
      drive(4'b1110, 8'h9F, 3);
      drive(4'b1110, 8'h71, 3);
    end
    drive(4'hF, 8'hFF, 6);
    n_checks++; if (fv_cnt - bf !== 0) begin n_fail++; $display("FAIL unstable_fv: got %0d expected 0", fv_cnt - bf); end
    n_checks++; if (err_cnt - be !== 0) begin n_fail++; $display("FAIL unstable_err: got %0d expected 0", err_cnt - be); end
    drive(4'b1101, 8'h71, 8);
    drive(4'b1011, 8'h11, 8);
    drive(4'b0111, 8'h49, 8);
    drive(4'hF, 8'hFF, 8);
    n_checks++; if (fv_cnt - bf !== 0) begin n_fail++; $display("FAIL unstable_pos1_marked: got %0d frames expected 0", fv_cnt - bf); end
    pulse_reset();
  endtask

  task automatic test_illegal_pattern();
    int bf, be;
    bf = fv_cnt; be = err_cnt;
    drive(4'b1110, 8'h7F, 8);
    drive(4'hF, 8'hFF, 4);
    n_checks++; if (err_cnt - be !== 1) begin n_fail++; $display("FAIL illpat_err: got %0d expected 1", err_cnt - be); end
    drive(4'b1101, 8'h71, 8);
    drive(4'b1011, 8'h11, 8);
    drive(4'b0111, 8'h49, 8);
    drive(4'hF, 8'hFF, 8);
    n_checks++; if (fv_cnt - bf !== 0) begin n_fail++; $display("FAIL illpat_pos1_marked: got %0d frames expected 0", fv_cnt - bf); end
    drive(4'b1110, 8'h03, 8);
    drive(4'hF, 8'hFF, 8);
    n_checks++; if (fv_cnt - bf !== 1) begin n_fail++; $display("FAIL illpat_recover_fv: got %0d expected 1", fv_cnt - bf); end
    n_checks++; if ({Q4, Q3, Q2, Q1} !== 16'h5AF0) begin n_fail++; $display("FAIL illpat_recover_q: got %h expected 5af0", {Q4, Q3, Q2, Q1}); end
    pulse_reset();
  endtask

  task automatic test_illegal_digit();
    int bf, be;
    bf = fv_cnt; be = err_cnt;
    drive(4'b1100, 8'h9F, 8);
    drive(4'hF, 8'hFF, 4);
    n_checks++; if (err_cnt - be !== 1) begin n_fail++; $display("FAIL illdig_err: got %0d expected 1", err_cnt - be); end
    drive(4'b1011, 8'h11, 8);
    drive(4'b0111, 8'h49, 8);
    drive(4'hF, 8'hFF, 8);
    n_checks++; if (fv_cnt - bf !== 0) begin n_fail++; $display("FAIL illdig_pos12_marked: got %0d frames expected 0", fv_cnt - bf); end
    drive(4'b1110, 8'h9F, 8);
    drive(4'b1101, 8'h71, 8);
    drive(4'hF, 8'hFF, 8);
    n_checks++; if (fv_cnt - bf !== 1) begin n_fail++; $display("FAIL illdig_recover_fv: got %0d expected 1", fv_cnt - bf); end
    n_checks++; if ({Q4, Q3, Q2, Q1} !== 16'h5AF1) begin n_fail++; $display("FAIL illdig_recover_q: got %h expected 5af1", {Q4, Q3, Q2, Q1}); end
    pulse_reset();
  endtask

  task automatic test_back_to_back();
    int bf, be;
    logic [3:0] exp_dp;
`ifdef SEG7_DEC_DP_EN
    exp_dp = 4'b0010;
`else
    exp_dp = 4'b0000;
`endif
    bf = fv_cnt; be = err_cnt;
    drive(4'b1110, 8'h9F, 4);
    drive(4'b1110, 8'h01, 4);
    drive(4'b1101, 8'h70, 4);
    drive(4'b1011, 8'h63, 4);
    drive(4'b0111, 8'h85, 4);
    drive(4'hF, 8'hFF, 6);
    n_checks++; if (fv_cnt - bf !== 1) begin n_fail++; $display("FAIL b2b_first_fv: got %0d expected 1", fv_cnt - bf); end
    n_checks++; if ({Q4, Q3, Q2, Q1} !== 16'hDCF8) begin n_fail++; $display("FAIL b2b_overwrite_q: got %h expected dcf8", {Q4, Q3, Q2, Q1}); end
    n_checks++; if (DP !== exp_dp) begin n_fail++; $display("FAIL b2b_dp: got %b expected %b", DP, exp_dp); end
    drive(4'b1110, 8'h03, 4);
    drive(4'b1101, 8'h25, 4);
    drive(4'b1011, 8'h1F, 4);
    drive(4'b0111, 8'h61, 4);
    drive(4'hF, 8'hFF, 6);
    n_checks++; if (fv_cnt - bf !== 2) begin n_fail++; $display("FAIL b2b_second_fv: got %0d expected 2", fv_cnt - bf); end
    n_checks++; if ({Q4, Q3, Q2, Q1} !== 16'hE720) begin n_fail++; $display("FAIL b2b_second_q: got %h expected e720", {Q4, Q3, Q2, Q1}); end
    n_checks++; if ({DP, 4'(err_cnt - be)} !== 8'h00) begin n_fail++; $display("FAIL b2b_dp_err: got %h expected 00", {DP, 4'(err_cnt - be)}); end
  endtask

  task automatic test_reset_midframe();
    int bf;
    bf = fv_cnt;
    drive(4'b1110, 8'h9F, 8);
    drive(4'b1101, 8'h71, 8);
    drive(4'hF, 8'hFF, 4);
    pulse_reset();
    drive(4'b1011, 8'h63, 8);
    drive(4'b0111, 8'h85, 8);
    drive(4'hF, 8'hFF, 8);
    n_checks++; if (fv_cnt - bf !== 0) begin n_fail++; $display("FAIL midreset_partial_fv: got %0d expected 0", fv_cnt - bf); end
    n_checks++; if ({Q4, Q3, Q2, Q1} !== 16'h0000) begin n_fail++; $display("FAIL midreset_q_zero: got %h expected 0000", {Q4, Q3, Q2, Q1}); end
    drive(4'b1110, 8'h25, 8);
    drive(4'b1101, 8'h1F, 8);
    drive(4'hF, 8'hFF, 8);
    n_checks++; if (fv_cnt - bf !== 1) begin n_fail++; $display("FAIL midreset_full_fv: got %0d expected 1", fv_cnt - bf); end
    n_checks++; if ({Q4, Q3, Q2, Q1} !== 16'hDC72) begin n_fail++; $display("FAIL midreset_q: got %h expected dc72", {Q4, Q3, Q2, Q1}); end
    n_checks++; if (qchg_bad !== 0) begin n_fail++; $display("FAIL q_change_without_fv: got %0d expected 0", qchg_bad); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_async_reset();
    test_unstable();
    test_illegal_pattern();
    test_illegal_digit();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
